// File: rtl/hdlgenius_pkg.sv
// rtl/hdlgenius_pkg.sv - shared FSM encoding, sequence geometry and debounce default
package hdlgenius_pkg;

    localparam int P_SYM_W       = 2;
    localparam int P_MAX_RND     = 16;
    localparam int P_DEB_DEFAULT = 500000;
    localparam int P_CNT_W       = 5;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WAIT_PRESS = 2'd1,
        ST_WAIT_REL   = 2'd2,
        ST_DONE       = 2'd3
    } cap_state_t;

    function automatic logic [P_CNT_W-1:0] clamp_round(input logic [P_CNT_W-1:0] r);
        return (r > P_CNT_W'(P_MAX_RND)) ? P_CNT_W'(P_MAX_RND) : r;
    endfunction

endpackage

// File: rtl/user_seq_capture_if.sv
// rtl/user_seq_capture_if.sv - control/datapath side of the answer-capture block
interface user_seq_capture_if;
    import hdlgenius_pkg::*;

    logic                           E;
    logic [P_CNT_W-1:0]             round;
    logic [P_SYM_W*P_MAX_RND-1:0]   fpga_seq;
    logic [P_SYM_W*P_MAX_RND-1:0]   user_seq;
    logic [P_CNT_W-1:0]             count;
    logic                           key_valid;
    logic                           end_User;
    logic                           match;

    modport master (
        output E, round, fpga_seq,
        input  user_seq, count, key_valid, end_User, match
    );

    modport slave (
        input  E, round, fpga_seq,
        output user_seq, count, key_valid, end_User, match
    );

endinterface

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - 2-FF synchroniser and counter debounce for one active-low key
module key_debounce #(
    parameter int P_DEB = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic pressed
);

    localparam int CW = $clog2(P_DEB + 1);

    // UNARMED behaves like "pressed" internally but is invisible outside, so a key
    // held through reset must first be seen released before it can register a press.
    typedef enum logic [1:0] {
        DB_UNARMED  = 2'd0,
        DB_RELEASED = 2'd1,
        DB_PRESSED  = 2'd2
    } db_state_t;

    db_state_t      st, st_n;
    logic           sync1, sync2;
    logic [CW-1:0]  cnt, cnt_n;
    logic           differ;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            cnt   <= '0;
            st    <= DB_UNARMED;
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
            cnt   <= cnt_n;
            st    <= st_n;
        end
    end

    always_comb begin
        st_n   = st;
        cnt_n  = '0;
        differ = (st == DB_RELEASED) ? ~sync2 : sync2;
        if (differ) begin
            if (cnt == CW'(P_DEB - 1)) begin
                st_n = (st == DB_RELEASED) ? DB_PRESSED : DB_RELEASED;
            end else begin
                cnt_n = cnt + 1'b1;
            end
        end
    end

    assign pressed = (st == DB_PRESSED);

endmodule

// File: rtl/user_seq_capture.sv
// rtl/user_seq_capture.sv - debounced key capture and compare of the player's sequence
// Optional: EARLY_ABORT_EN ends the answer on the first wrong symbol.
module user_seq_capture
    import hdlgenius_pkg::*;
#(
    parameter int P_KEY = 4,
    parameter int P_DEB = P_DEB_DEFAULT
) (
    input  logic                CLOCK_50,
    input  logic                R,
    input  logic [P_KEY-1:0]    KEY,
    user_seq_capture_if.slave   bus
);

    localparam int IDX_W = $clog2(P_MAX_RND);

    cap_state_t             state, state_n;
    logic [P_KEY-1:0]       pressed, pressed_q, edges;
    logic [P_SYM_W-1:0]     key_idx;
    logic [P_SYM_W-1:0]     sym_q [P_MAX_RND];
    logic [P_CNT_W-1:0]     count_q;
    logic [P_CNT_W-1:0]     round_c;
    logic                   key_valid_q;
    logic                   do_clear, do_accept;
    logic                   all_eq;
`ifdef EARLY_ABORT_EN
    logic                   mismatch_q;
`endif

    for (genvar g = 0; g < P_KEY; g++) begin : g_deb
        key_debounce #(.P_DEB(P_DEB)) u_deb (
            .clk     (CLOCK_50),
            .rst     (R),
            .key_n   (KEY[g]),
            .pressed (pressed[g])
        );
    end

    // Only fresh press edges count, so a key held when E rises is ignored.
    always_ff @(posedge CLOCK_50) begin
        if (R) pressed_q <= '0;
        else   pressed_q <= pressed;
    end

    assign edges   = pressed & ~pressed_q;
    assign round_c = clamp_round(bus.round);

    always_comb begin
        key_idx = '0;
        for (int i = 0; i < P_KEY; i++) begin
            if (pressed[i]) key_idx = P_SYM_W'(i);
        end
    end

    always_comb begin
        all_eq = 1'b1;
        for (int i = 0; i < P_MAX_RND; i++) begin
            if ((P_CNT_W'(i) < round_c) &&
                (sym_q[i] != bus.fpga_seq[i*P_SYM_W +: P_SYM_W])) begin
                all_eq = 1'b0;
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (R) state <= ST_IDLE;
        else   state <= state_n;
    end

    always_comb begin
        state_n   = state;
        do_clear  = 1'b0;
        do_accept = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.E) begin
                    do_clear = 1'b1;
                    state_n  = (round_c == '0) ? ST_DONE : ST_WAIT_PRESS;
                end
            end
            ST_WAIT_PRESS: begin
                if (edges != '0) begin
                    if ($onehot(pressed) && (edges == pressed) && (count_q < round_c)) begin
                        do_accept = 1'b1;
                    end
                    state_n = ST_WAIT_REL;
                end
            end
            ST_WAIT_REL: begin
                if (pressed == '0) begin
                    state_n = (count_q == round_c) ? ST_DONE : ST_WAIT_PRESS;
                end
`ifdef EARLY_ABORT_EN
                if (mismatch_q) state_n = ST_DONE;
`endif
            end
            ST_DONE: begin
                state_n = ST_DONE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
        if (!bus.E) begin
            state_n   = ST_IDLE;
            do_clear  = 1'b0;
            do_accept = 1'b0;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (R) begin
            for (int i = 0; i < P_MAX_RND; i++) sym_q[i] <= '0;
            count_q     <= '0;
            key_valid_q <= 1'b0;
        end else begin
            key_valid_q <= do_accept;
            if (do_clear) begin
                for (int i = 0; i < P_MAX_RND; i++) sym_q[i] <= '0;
                count_q <= '0;
            end else if (do_accept) begin
                sym_q[count_q[IDX_W-1:0]] <= key_idx;
                count_q                   <= count_q + 1'b1;
            end
        end
    end

`ifdef EARLY_ABORT_EN
    always_ff @(posedge CLOCK_50) begin
        if (R || do_clear) begin
            mismatch_q <= 1'b0;
        end else if (do_accept &&
                     (key_idx != bus.fpga_seq[count_q[IDX_W-1:0]*P_SYM_W +: P_SYM_W])) begin
            mismatch_q <= 1'b1;
        end
    end
`endif

    always_comb begin
        for (int i = 0; i < P_MAX_RND; i++) begin
            bus.user_seq[i*P_SYM_W +: P_SYM_W] = sym_q[i];
        end
    end

    assign bus.count     = count_q;
    assign bus.key_valid = key_valid_q;
    assign bus.end_User  = (state == ST_DONE);
    assign bus.match     = (state == ST_DONE) && all_eq;

endmodule
